// File: rtl/mem_arbiter_if.sv
// Line-fill/write-back bus used between a cache client, the arbiter and physical memory.
// The requester drives through the master modport; the responder through slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (
    output read, write, address, wdata,
    input  rdata, resp
  );

  modport slave (
    input  read, write, address, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between an I-cache
// (line fills only) and a D-cache (line fills and write-backs).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  i_pmem,
  mem_arbiter_if.slave  d_pmem,
  mem_arbiter_if.master pmem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t state;
  state_t state_nxt;
  grant_t last_grant;
  grant_t last_grant_nxt;

  logic i_req;
  logic d_req;

  assign i_req = i_pmem.read;
  assign d_req = d_pmem.read | d_pmem.write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Grant is decided only from IDLE; a busy owner keeps the port until pmem
  // answers, which also forces one idle cycle between back-to-back grants.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant == GRANT_D) begin
            state_nxt      = I_BUSY;
            last_grant_nxt = GRANT_I;
          end else begin
            state_nxt      = D_BUSY;
            last_grant_nxt = GRANT_D;
          end
        end else if (i_req) begin
          state_nxt      = I_BUSY;
          last_grant_nxt = GRANT_I;
        end else if (d_req) begin
          state_nxt      = D_BUSY;
          last_grant_nxt = GRANT_D;
        end
      end
      I_BUSY: begin
        if (pmem.resp) state_nxt = IDLE;
      end
      D_BUSY: begin
        if (pmem.resp) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory-side request mux; write-back wins over a concurrent D fill request.
  always_comb begin
    pmem.read    = 1'b0;
    pmem.write   = 1'b0;
    pmem.address = '0;
    pmem.wdata   = '0;
    unique case (state)
      I_BUSY: begin
        pmem.read    = 1'b1;
        pmem.address = i_pmem.address;
      end
      D_BUSY: begin
        pmem.address = d_pmem.address;
        pmem.wdata   = d_pmem.wdata;
        if (d_pmem.write) begin
          pmem.write = 1'b1;
        end else begin
          pmem.read  = d_pmem.read;
        end
      end
      default: begin
        pmem.read = 1'b0;
      end
    endcase
  end

  assign i_pmem.resp  = (state == I_BUSY) & pmem.resp;
  assign d_pmem.resp  = (state == D_BUSY) & pmem.resp;
  assign i_pmem.rdata = pmem.rdata;
  assign d_pmem.rdata = pmem.rdata;

`ifndef SYNTHESIS
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset)
    !(pmem.read && pmem.write));
  a_one_resp: assert property (@(posedge clk) disable iff (!reset)
    !(i_pmem.resp && d_pmem.resp));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic clk;
  logic reset;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) i_if ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) d_if ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) p_if ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_pmem (i_if.slave),
    .d_pmem (d_if.slave),
    .pmem   (p_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;

  // Model: who currently owns the memory port (0 none, 1 I, 2 D) and who was last served.
  int owner;
  int last;

  typedef struct {
    logic          ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd;
    logic          pr;
    logic [LW-1:0] rd;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_ad;
    logic [LW-1:0] e_wd;
    logic          e_ir, e_dr;
    string         nm;
  } vec_t;

  vec_t vq[$];

  localparam logic [LW-1:0] A5 = {16{8'hA5}};
  localparam logic [LW-1:0] WD = 128'h0123456789ABCDEF0123456789ABCDEF;

  task automatic cmp(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic ir, dr, dw, input logic [AW-1:0] ia, da,
                     input logic [LW-1:0] wd, input logic pr, input logic [LW-1:0] rd,
                     input logic e_rd, e_wr, input logic [AW-1:0] e_ad,
                     input logic [LW-1:0] e_wd, input logic e_ir, e_dr, input string nm);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.wd = wd;
    v.pr = pr; v.rd = rd; v.e_rd = e_rd; v.e_wr = e_wr; v.e_ad = e_ad;
    v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr; v.nm = nm;
    vq.push_back(v);
  endtask

  task automatic drive(input logic ir, dr, dw, input logic [AW-1:0] ia, da,
                       input logic [LW-1:0] wd, input logic pr, input logic [LW-1:0] rd);
    i_if.read = ir; d_if.read = dr; d_if.write = dw;
    i_if.address = ia; d_if.address = da; d_if.wdata = wd;
    p_if.resp = pr; p_if.rdata = rd;
  endtask

  task automatic model_reset();
    owner = 0;
    last  = 2;
  endtask

  task automatic model_advance();
    bit wi, wd_;
    wi  = i_if.read;
    wd_ = d_if.read | d_if.write;
    if (owner == 0) begin
      if (wi && wd_) owner = (last == 2) ? 1 : 2;
      else if (wi)   owner = 1;
      else if (wd_)  owner = 2;
      if (owner != 0) last = owner;
    end else if (p_if.resp) begin
      owner = 0;
    end
  endtask

  task automatic model_check(input string nm);
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_ad;
    logic [LW-1:0] e_wd;
    e_wr = (owner == 2) && d_if.write;
    e_rd = (owner == 1) || ((owner == 2) && !d_if.write && d_if.read);
    e_ad = (owner == 1) ? i_if.address : (owner == 2) ? d_if.address : '0;
    e_wd = (owner == 2) ? d_if.wdata : '0;
    e_ir = (owner == 1) && p_if.resp;
    e_dr = (owner == 2) && p_if.resp;
    cmp({nm, ".read"},  LW'(p_if.read),    LW'(e_rd));
    cmp({nm, ".write"}, LW'(p_if.write),   LW'(e_wr));
    cmp({nm, ".addr"},  LW'(p_if.address), LW'(e_ad));
    cmp({nm, ".wdata"}, p_if.wdata,        e_wd);
    cmp({nm, ".iresp"}, LW'(i_if.resp),    LW'(e_ir));
    cmp({nm, ".dresp"}, LW'(d_if.resp),    LW'(e_dr));
    cmp({nm, ".irdata"}, i_if.rdata,       p_if.rdata);
    cmp({nm, ".drdata"}, d_if.rdata,       p_if.rdata);
  endtask

  // Entered at posedge+1 with inputs set; checks mid-cycle, returns at next posedge+1.
  task automatic step(input string nm);
    @(negedge clk);
    model_check(nm);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    i_if.write = 1'b0;
    i_if.wdata = '0;
    reset = 1'b0;
    drive(1, 1, 0, 16'h1111, 16'h2222, WD, 1, A5);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst.read",  LW'(p_if.read),    '0);
    cmp("rst.write", LW'(p_if.write),   '0);
    cmp("rst.addr",  LW'(p_if.address), '0);
    cmp("rst.wdata", p_if.wdata,        '0);
    cmp("rst.iresp", LW'(i_if.resp),    '0);
    cmp("rst.dresp", LW'(d_if.resp),    '0);
    drive(0, 0, 0, '0, '0, '0, 0, '0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    add(1,0,0,16'h1230,16'h0000,'0,0,'0,  0,0,16'h0000,'0,0,0, "i_req_idle");
    add(1,0,0,16'h1230,16'h0000,'0,0,'0,  1,0,16'h1230,'0,0,0, "i_busy");
    add(1,0,0,16'h1230,16'h0000,'0,1,A5,  1,0,16'h1230,'0,1,0, "i_resp");
    add(0,0,0,16'h1230,16'h0000,'0,0,'0,  0,0,16'h0000,'0,0,0, "i_done");
    add(0,1,1,16'h0000,16'h2000,WD,0,'0,  0,0,16'h0000,'0,0,0, "wb_req");
    add(0,1,1,16'h0000,16'h2000,WD,0,'0,  0,1,16'h2000,WD,0,0, "wb_busy");
    add(0,1,1,16'h0000,16'h2000,WD,1,A5,  0,1,16'h2000,WD,0,1, "wb_resp");
    add(0,0,0,16'h0000,16'h2000,WD,0,'0,  0,0,16'h0000,'0,0,0, "wb_done");
    add(1,1,0,16'h0040,16'h8000,'0,0,'0,  0,0,16'h0000,'0,0,0, "both_req");
    add(1,1,0,16'h0040,16'h8000,'0,0,'0,  1,0,16'h0040,'0,0,0, "i_first");
    add(1,1,0,16'h0040,16'h8000,'0,1,~A5, 1,0,16'h0040,'0,1,0, "i_first_resp");
    add(0,1,0,16'h0040,16'h8000,'0,0,'0,  0,0,16'h0000,'0,0,0, "rr_gap");
    add(0,1,0,16'h0040,16'h8000,'0,0,'0,  1,0,16'h8000,'0,0,0, "d_second");
    add(0,1,0,16'h0040,16'h8000,'0,1,A5,  1,0,16'h8000,'0,0,1, "d_second_resp");
    add(0,0,0,16'h0000,16'h0000,'0,0,'0,  0,0,16'h0000,'0,0,0, "all_idle");

    foreach (vq[k]) begin
      drive(vq[k].ir, vq[k].dr, vq[k].dw, vq[k].ia, vq[k].da, vq[k].wd, vq[k].pr, vq[k].rd);
      @(negedge clk);
      cmp({vq[k].nm, ".read"},   LW'(p_if.read),    LW'(vq[k].e_rd));
      cmp({vq[k].nm, ".write"},  LW'(p_if.write),   LW'(vq[k].e_wr));
      cmp({vq[k].nm, ".addr"},   LW'(p_if.address), LW'(vq[k].e_ad));
      cmp({vq[k].nm, ".wdata"},  p_if.wdata,        vq[k].e_wd);
      cmp({vq[k].nm, ".iresp"},  LW'(i_if.resp),    LW'(vq[k].e_ir));
      cmp({vq[k].nm, ".dresp"},  LW'(d_if.resp),    LW'(vq[k].e_dr));
      cmp({vq[k].nm, ".irdata"}, i_if.rdata,        vq[k].rd);
      cmp({vq[k].nm, ".drdata"}, d_if.rdata,        vq[k].rd);
      model_advance();
      @(posedge clk);
      #1;
    end

    // Both clients hammering: grants must alternate I, D, I, D.
    for (int t = 0; t < 4; t++) begin
      drive(1, 1, 0, 16'h1000, 16'h9000, '0, 0, {4{$urandom}});
      step("rr_idle");
      cmp("rr_order", LW'(p_if.address), (t % 2 == 0) ? LW'(16'h1000) : LW'(16'h9000));
      step("rr_wait");
      p_if.resp = 1'b1;
      step("rr_resp");
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), 1'($urandom), ($urandom % 4) == 0, AW'($urandom), AW'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, ($urandom % 4) == 0,
            {$urandom, $urandom, $urandom, $urandom});
      step("rand");
    end

    // Reach IDLE, then grant I and pull reset between clock edges.
    drive(0, 0, 0, '0, '0, '0, 1, '0);
    step("flush");
    drive(1, 0, 0, 16'h0ABC, '0, '0, 0, A5);
    step("pre_rst");
    #2;
    cmp("busy_read", LW'(p_if.read), LW'(1'b1));
    reset = 1'b0;
    #1;
    cmp("async_rst.read", LW'(p_if.read),    '0);
    cmp("async_rst.addr", LW'(p_if.address), '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    i_if.read = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    p_if.resp = 1'b1;
    step("late_resp");
    cmp("late_resp.iresp_hold", LW'(i_if.resp), '0);

    // Right after reset both requesting: I wins.
    drive(1, 1, 0, 16'h0ABC, 16'h7000, '0, 0, '0);
    step("post_rst_req");
    cmp("first_grant_i", LW'(p_if.address), LW'(16'h0ABC));
    p_if.resp = 1'b1;
    step("post_rst_resp");

    // D owner drops its request while memory stalls: port must stay put.
    drive(0, 1, 0, '0, 16'h3C00, WD, 0, '0);
    step("stall_req");
    d_if.read = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step("stall");
      cmp("stall_addr", LW'(p_if.address), LW'(16'h3C00));
    end
    p_if.resp = 1'b1;
    step("stall_resp");
    p_if.resp = 1'b0;
    step("stall_done");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 16, byte-address width.
REQ-002 The block SHALL expose parameter LINE_W, default 128, cache-line width in bits (8 LC-3b words).
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-005 i_pmem_read  input  1  I-cache line-fill request.
REQ-006 i_pmem_address  input  ADDR_W  I-cache line address.
REQ-007 i_pmem_rdata  output  LINE_W  fill data returned to I-cache.
REQ-008 i_pmem_resp  output  1  I-cache transaction complete.
REQ-009 d_pmem_read  input  1  D-cache line-fill request.
REQ-010 d_pmem_write  input  1  D-cache line write-back request.
REQ-011 d_pmem_address  input  ADDR_W  D-cache line address.
REQ-012 d_pmem_wdata  input  LINE_W  D-cache write-back data.
REQ-013 d_pmem_rdata  output  LINE_W  fill data returned to D-cache.
REQ-014 d_pmem_resp  output  1  D-cache transaction complete.
REQ-015 pmem_read  output  1  read request to physical memory.
REQ-016 pmem_write  output  1  write request to physical memory.
REQ-017 pmem_address  output  ADDR_W  physical memory line address.
REQ-018 pmem_wdata  output  LINE_W  physical memory write data.
REQ-019 pmem_rdata  input  LINE_W  physical memory read data.
REQ-020 pmem_resp  input  1  physical memory transaction complete, one-cycle pulse.

Function
REQ-021 FSM SHALL have states IDLE, I_BUSY, D_BUSY, plus a 1-bit last_grant register (I or D).
REQ-022 In IDLE, pmem_read, pmem_write, pmem_address, pmem_wdata, i_pmem_resp, d_pmem_resp SHALL all be 0.
REQ-023 IDLE, only I requesting (i_pmem_read=1) -> I_BUSY next edge; only D requesting (d_pmem_read|d_pmem_write) -> D_BUSY next edge.
REQ-024 IDLE, both requesting -> grant the client not equal to last_grant (round-robin).
REQ-025 On every IDLE->I_BUSY or IDLE->D_BUSY transition, last_grant SHALL update to the granted client.
REQ-026 I_BUSY: pmem_read=1, pmem_write=0, pmem_address=i_pmem_address, pmem_wdata=0.
REQ-027 D_BUSY: pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata; if d_pmem_write=1 then pmem_write=1, pmem_read=0, else pmem_read=d_pmem_read, pmem_write=0.
REQ-028 Grant latency SHALL be exactly one cycle: request sampled in IDLE, pmem request driven the following cycle.
REQ-029 i_pmem_resp SHALL equal pmem_resp while in I_BUSY, else 0; d_pmem_resp SHALL equal pmem_resp while in D_BUSY, else 0 (combinational, same cycle).
REQ-030 i_pmem_rdata and d_pmem_rdata SHALL both be driven with pmem_rdata unconditionally; validity is qualified only by the respective resp.
REQ-031 BUSY state with pmem_resp=1 -> IDLE next edge; guarantees one idle cycle between transactions so the client can deassert its request.
REQ-032 BUSY state with pmem_resp=0 SHALL hold state regardless of client request levels (clients must hold request until resp).
REQ-033 No client SHALL ever see resp for a transaction it was not granted.
REQ-034 The FSM SHALL never issue pmem_read and pmem_write in the same cycle.

Reset
REQ-035 reset=0 SHALL asynchronously force state=IDLE, last_grant=D, all outputs per REQ-022, independent of clk.
REQ-036 reset asserted mid-transaction SHALL abandon it; no resp pulse is generated to either client after reset release until a new grant.
REQ-037 After reset release with both clients requesting, first grant SHALL go to I (since last_grant=D).

Verification
REQ-038 Reset, then i_pmem_read=1 addr 0x1230 -> cycle+1 pmem_read=1 addr 0x1230; pmem_resp pulse with rdata 0xA5..A5 -> i_pmem_resp=1 same cycle, i_pmem_rdata matches, IDLE next cycle.
REQ-039 Simultaneous I read 0x0040 and D read 0x8000 after reset -> I granted first; after its resp and one IDLE cycle, D granted with pmem_address=0x8000.
REQ-040 Both requesting continuously for 4 transactions -> grant order I,D,I,D; d_pmem_resp never asserted during I_BUSY and vice versa.
REQ-041 D write-back addr 0x2000, wdata 0x0123..CDEF, with d_pmem_read also 1 -> pmem_write=1, pmem_read=0, pmem_wdata matches; d_pmem_resp on pmem_resp.
REQ-042 Assert reset=0 asynchronously (between edges) during I_BUSY -> pmem_read drops to 0 immediately; late pmem_resp after release produces no i_pmem_resp.
REQ-043 pmem_resp held 0 for 20 cycles in D_BUSY while D drops request -> state and pmem_address held unchanged until pmem_resp.
